// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: arbiter state and owner encodings, plus counter sizing,
// shared by the arbiter and the DMA engine's debug decode.
package ram_arbiter_pkg;
   typedef enum logic [1:0] {S_CPU = 2'd0, S_FORCE = 2'd1, S_BURST = 2'd2} state_t;
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;
   function automatic int cnt_w(input int lim);
      return (lim < 1) ? 1 : $clog2(lim + 1);
   endfunction
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: saturating up-counter with priority clear; at_limit flags
// that the count has reached LIMIT.
module arb_sat_counter
   import ram_arbiter_pkg::*;
#(
   parameter int LIMIT = 7,
   parameter int W     = cnt_w(LIMIT)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      at_limit = cnt_q == W'(LIMIT);
      cnt_d    = clr ? '0 : (inc && !at_limit) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port system RAM between the CPU (priority)
// and a DMA requester with starvation protection and locked bursts.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int AW        = 16,
   parameter int DW        = 8,
   parameter int MAX_WAIT  = 7,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic          dma_lock,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);
   // wait counter flags the last conflict the CPU may still win
   localparam int   WAIT_LIM  = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
   localparam int   BURST_LIM = (MAX_BURST > 1) ? MAX_BURST - 1 : 0;
   localparam logic DMA_FIRST = MAX_WAIT == 0;
   state_t state_q, state_d;
   logic   owner_q, owner_d, rvalid_q, rvalid_d;
   logic   in_burst, in_force, wait_last, burst_last, force_next, burst_next;
   logic   wait_clr, wait_inc, burst_clr, burst_inc;
   always_comb begin
      in_burst   = state_q == S_BURST;
      in_force   = state_q == S_FORCE;
      dma_gnt    = reset & dma_req & (in_burst | in_force | ~cpu_req | DMA_FIRST);
      cpu_gnt    = reset & cpu_req & ~in_burst & ~dma_gnt;
      force_next = cpu_gnt & dma_req & wait_last;
      burst_next = dma_gnt & dma_lock & ~burst_last;
      state_d    = burst_next ? S_BURST : force_next ? S_FORCE : S_CPU;
      wait_clr   = dma_gnt | ~dma_req;
      wait_inc   = cpu_gnt & dma_req;
      burst_clr  = ~burst_next;
      burst_inc  = dma_gnt;
      ram_cs     = cpu_gnt | dma_gnt;
      ram_we     = cpu_gnt ? cpu_we : dma_gnt & dma_we;
      ram_addr   = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : '0;
      ram_wdata  = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
      rvalid_d   = ram_cs & ~ram_we;
      owner_d    = dma_gnt ? OWN_DMA : OWN_CPU;
      cpu_rvalid = rvalid_q & (owner_q == OWN_CPU);
      dma_rvalid = rvalid_q & (owner_q == OWN_DMA);
      cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
      dma_rdata  = dma_rvalid ? ram_rdata : '0;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q  <= S_CPU;
         owner_q  <= OWN_CPU;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rvalid_q <= rvalid_d;
      end
   arb_sat_counter #(.LIMIT(WAIT_LIM)) u_wait (
      .clk      (clk),
      .reset    (reset),
      .clr      (wait_clr),
      .inc      (wait_inc),
      .at_limit (wait_last)
   );
   arb_sat_counter #(.LIMIT(BURST_LIM)) u_burst (
      .clk      (clk),
      .reset    (reset),
      .clr      (burst_clr),
      .inc      (burst_inc),
      .at_limit (burst_last)
   );
endmodule
